// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared encodings and round-robin helper for the elevator call panel
package elevator_pkg;

   localparam int NUM_FLOORS = 3;

   // Floor indices double as bit positions in call_in / pending
   localparam logic [1:0] FLOOR_1 = 2'd0;
   localparam logic [1:0] FLOOR_2 = 2'd1;
   localparam logic [1:0] FLOOR_3 = 2'd2;

   localparam logic [1:0] ST_IDLE        = 2'd0;
   localparam logic [1:0] ST_ISSUE       = 2'd1;
   localparam logic [1:0] ST_WAIT_ARRIVE = 2'd2;
   localparam logic [1:0] ST_DWELL       = 2'd3;

   // First pending floor found searching upward from last+1, wrapping floor 3 -> floor 1
   function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
      logic [1:0] idx;
      logic       found;
      idx     = last;
      found   = 1'b0;
      rr_pick = last;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         idx = (idx == FLOOR_3) ? FLOOR_1 : idx + 2'd1;
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/elevator_call_panel_if.sv
// rtl/elevator_call_panel_if.sv - request/arrival signals between call panel and elevator controller
interface elevator_call_panel_if;
   logic button_1;
   logic button_2;
   logic button_3;
   logic hold;
   logic lock;
   logic floor_1;
   logic floor_2;
   logic floor_3;

   modport master (
      output button_1, button_2, button_3, hold, lock,
      input  floor_1, floor_2, floor_3
   );

   modport slave (
      input  button_1, button_2, button_3, hold, lock,
      output floor_1, floor_2, floor_3
   );
endinterface

// File: rtl/elevator_btn_debounce.sv
// rtl/elevator_btn_debounce.sv - 2-FF synchronizer plus debounce counter for one call button
module elevator_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic rise
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync_1;
   logic          sync_2;
   logic          level;
   logic [CW-1:0] cnt;
   logic          settle;

   // Level flips on the sample that completes the run, so rise lines up with that edge
   assign settle = (sync_2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign rise   = settle && sync_2;

   // Synchronize, then count consecutive samples that disagree with the accepted level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         level  <= 1'b0;
         cnt    <= '0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
         if (sync_2 == level) begin
            cnt <= '0;
         end else if (settle) begin
            level <= sync_2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/elevator_call_panel.sv
// rtl/elevator_call_panel.sv - passenger call panel issuing one request at a time to the controller
module elevator_call_panel
   import elevator_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 64,
   parameter int DWELL_CYCLES    = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            call_in,
   input  logic                  lock_sw,
   elevator_call_panel_if.master ctrl,
   output logic [2:0]            pending,
   output logic                  timeout_err
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int DW = $clog2(DWELL_CYCLES + 1);

   logic [2:0]    rise_vec;
   logic [2:0]    floor_vec;
   logic [2:0]    clr_vec;
   logic          lock_s1;
   logic          lock_s2;
   logic [1:0]    state;
   logic [1:0]    target;
   logic [1:0]    last_served;
   logic [TW-1:0] tmo_cnt;
   logic [DW-1:0] dwell_cnt;
   logic          arrived;

   for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
      elevator_btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .raw     (call_in[g]),
         .rise    (rise_vec[g])
      );
   end

   // Key switch only needs metastability protection, not debouncing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_s1 <= 1'b0;
         lock_s2 <= 1'b0;
      end else begin
         lock_s1 <= lock_sw;
         lock_s2 <= lock_s1;
      end
   end

   assign floor_vec = {ctrl.floor_3, ctrl.floor_2, ctrl.floor_1};
   assign arrived   = (state == ST_WAIT_ARRIVE) && floor_vec[target];
   assign clr_vec   = arrived ? (3'b001 << target) : 3'b000;

   // Call lamps: the car being at the floor beats a simultaneous new press
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending <= 3'b000;
      end else begin
         pending <= (pending | rise_vec) & ~clr_vec;
      end
   end

   // Request sequencer: pick, issue, wait for arrival or give up, dwell
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         target      <= FLOOR_1;
         last_served <= FLOOR_3;
         tmo_cnt     <= '0;
         dwell_cnt   <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if ((pending != 3'b000) && !lock_s2) begin
                  target <= rr_pick(pending, last_served);
                  state  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               tmo_cnt <= '0;
               state   <= ST_WAIT_ARRIVE;
            end
            ST_WAIT_ARRIVE: begin
               if (arrived) begin
                  last_served <= target;
                  dwell_cnt   <= '0;
                  state       <= ST_DWELL;
               end else if (lock_s2) begin
                  state <= ST_IDLE;
               end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  // Mark the stuck floor as served so the others get a turn
                  timeout_err <= 1'b1;
                  last_served <= target;
                  state       <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_DWELL: begin
               if (dwell_cnt == DW'(DWELL_CYCLES - 1)) begin
                  state <= ST_IDLE;
               end else begin
                  dwell_cnt <= dwell_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ctrl.button_1 = (state == ST_ISSUE) && (target == FLOOR_1);
   assign ctrl.button_2 = (state == ST_ISSUE) && (target == FLOOR_2);
   assign ctrl.button_3 = (state == ST_ISSUE) && (target == FLOOR_3);
   assign ctrl.hold     = (state == ST_DWELL) && (dwell_cnt == '0);
   assign ctrl.lock     = lock_s2;
endmodule

// File: tb/tb_elevator_call_panel.sv
// tb/tb_elevator_call_panel.sv - scoreboard bench for elevator_call_panel
module tb_elevator_call_panel;
   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] call_in;
   logic       lock_sw;
   logic [2:0] pending;
   logic       timeout_err;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         sb[$];
   int         mon_code;
   int         mon_exp;
   logic [3:0] mon_v;

   always #5 clk = ~clk;

   elevator_call_panel_if bus ();

   elevator_call_panel #(
      .DEBOUNCE_CYCLES (4),
      .TIMEOUT_CYCLES  (64),
      .DWELL_CYCLES    (8)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .call_in     (call_in),
      .lock_sw     (lock_sw),
      .ctrl        (bus),
      .pending     (pending),
      .timeout_err (timeout_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic btn(input int n);
      case (n)
         1: return bus.button_1;
         2: return bus.button_2;
         3: return bus.button_3;
         default: return 1'b0;
      endcase
   endfunction

   task automatic set_floor(input int f, input logic v);
      case (f)
         1: bus.floor_1 = v;
         2: bus.floor_2 = v;
         default: bus.floor_3 = v;
      endcase
   endtask

   task automatic press(input logic [2:0] mask, input int n);
      call_in = mask;
      ticks(n);
      call_in = 3'b000;
   endtask

   task automatic wait_btn(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && btn(n) !== 1'b1; i++) tick();
      check_eq(tag, btn(n), 1'b1);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) tick();
      check_eq(tag, sb.size(), 0);
   endtask

   // Car reports floor f for one cycle; a hold pulse and a cleared lamp must follow
   task automatic arrive(input int f);
      sb.push_back(4);
      set_floor(f, 1'b1);
      tick();
      check_eq("arrive_hold", bus.hold, 1'b1);
      check_eq("arrive_clr", pending[f-1], 1'b0);
      set_floor(f, 1'b0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      call_in = 3'b000;
      lock_sw = 1'b0;
      bus.floor_1 = 1'b0;
      bus.floor_2 = 1'b0;
      bus.floor_3 = 1'b0;
      ticks(2);
      check_eq("rst_pending", pending, 3'b000);
      check_eq("rst_outs", {bus.button_1, bus.button_2, bus.button_3, bus.hold, bus.lock, timeout_err}, 6'b0);
      reset_n = 1'b1;
   endtask

   // Every button/hold pulse is matched in order against the expected queue
   always @(negedge clk) begin
      mon_v = {bus.hold, bus.button_3, bus.button_2, bus.button_1};
      if (reset_n === 1'b1 && mon_v !== 4'b0000) begin
         check_eq("pulse_excl", $countones(mon_v), 1);
         mon_code = mon_v[3] ? 4 : mon_v[2] ? 3 : mon_v[1] ? 2 : 1;
         if (sb.size() == 0) begin
            check_eq("sb_unexpected", mon_code, 0);
         end else begin
            mon_exp = sb.pop_front();
            check_eq("sb_event", mon_code, mon_exp);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b1;
      call_in = 3'b000;
      lock_sw = 1'b0;
      bus.floor_1 = 1'b0;
      bus.floor_2 = 1'b0;
      bus.floor_3 = 1'b0;
      #1;
      do_reset();

      // Basic call: pending at press+6 edges, button_2 on the next edge
      sb.push_back(2);
      call_in = 3'b010;
      ticks(5);
      check_eq("pend_early", pending, 3'b000);
      tick();
      check_eq("pend_set", pending, 3'b010);
      tick();
      check_eq("btn2_pulse", bus.button_2, 1'b1);
      tick();
      check_eq("btn2_one", bus.button_2, 1'b0);
      ticks(2);
      call_in = 3'b000;
      ticks(2);
      arrive(2);
      check_eq("basic_pend0", pending, 3'b000);
      tick();
      check_eq("hold_one", bus.hold, 1'b0);
      ticks(9);
      wait_drain("basic_drain", 1);

      // Round-robin from reset: floor 1 before floor 3, re-press of 1 served after 3
      do_reset();
      sb.push_back(1);
      press(3'b101, 6);
      check_eq("rr_pend", pending, 3'b101);
      wait_btn("rr_btn1", 1, 5);
      ticks(2);
      arrive(1);
      check_eq("rr_left", pending, 3'b100);
      sb.push_back(3);
      wait_btn("rr_btn3", 3, 20);
      tick();
      press(3'b001, 6);
      check_eq("rr_repress", pending, 3'b101);
      arrive(3);
      sb.push_back(1);
      wait_btn("rr_btn1b", 1, 20);
      ticks(2);
      arrive(1);
      ticks(10);
      check_eq("rr_pend0", pending, 3'b000);
      wait_drain("rr_drain", 1);

      // Lock: two-cycle latency, calls held while locked, lock aborts a wait
      lock_sw = 1'b1;
      tick();
      check_eq("lock_lat1", bus.lock, 1'b0);
      tick();
      check_eq("lock_lat2", bus.lock, 1'b1);
      press(3'b100, 6);
      check_eq("lock_pend", pending, 3'b100);
      ticks(10);
      lock_sw = 1'b0;
      sb.push_back(3);
      wait_btn("lock_rel_btn3", 3, 10);
      ticks(2);
      lock_sw = 1'b1;
      ticks(5);
      check_eq("lock_wait_pend", pending, 3'b100);
      check_eq("lock_wait_err", timeout_err, 1'b0);
      ticks(10);
      lock_sw = 1'b0;
      sb.push_back(3);
      wait_btn("lock_rel_btn3b", 3, 10);
      ticks(2);
      arrive(3);
      ticks(10);
      wait_drain("lock_drain", 1);

      // Timeout: floor 1 never arrives; error at 64 wait cycles, then floor 2 is tried
      sb.push_back(1);
      press(3'b001, 6);
      wait_btn("tmo_btn1", 1, 5);
      press(3'b010, 6);
      ticks(58);
      check_eq("tmo_before", timeout_err, 1'b0);
      tick();
      check_eq("tmo_set", timeout_err, 1'b1);
      check_eq("tmo_pend", pending, 3'b011);
      sb.push_back(2);
      wait_btn("tmo_btn2", 2, 5);
      ticks(2);
      arrive(2);
      check_eq("tmo_sticky", timeout_err, 1'b1);
      check_eq("tmo_pend1", pending, 3'b001);
      sb.push_back(1);
      wait_btn("tmo_btn1b", 1, 20);
      ticks(2);
      arrive(1);
      ticks(10);
      check_eq("tmo_pend0", pending, 3'b000);
      wait_drain("tmo_drain", 1);

      // Debounce: 3-cycle glitch ignored, 4-cycle press accepted
      call_in = 3'b100;
      ticks(3);
      call_in = 3'b000;
      ticks(8);
      check_eq("glitch", pending, 3'b000);
      sb.push_back(3);
      call_in = 3'b100;
      ticks(4);
      call_in = 3'b000;
      ticks(2);
      check_eq("db_accept", pending, 3'b100);
      wait_drain("db_drain", 5);

      // Reset in the middle of WAIT_ARRIVE
      ticks(3);
      #3;
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_outs", {bus.button_1, bus.button_2, bus.button_3, bus.hold, bus.lock, timeout_err}, 6'b0);
      check_eq("mid_rst_pend", pending, 3'b000);
      tick();
      reset_n = 1'b1;
      ticks(10);
      check_eq("post_rst_pend", pending, 3'b000);
      wait_drain("final_drain", 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/elevator_call_panel.md
Name: elevator_call_panel

Overview:
- Passenger-side request initiator for the 3-floor elevator controller.
- Synchronizes and debounces raw call buttons and latches them as pending calls.
- Issues one-cycle button_N requests to the controller, one call at a time, then waits for the matching floor_N indication.
- On arrival, clears the call and pulses hold. Drives the controller's lock input from a synchronized key switch.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a button level is accepted.
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT_ARRIVE before the call is abandoned and timeout_err is set.
- DWELL_CYCLES, 8, cycles spent in DWELL after the hold pulse before the next call may be issued.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- call_in  in  3  raw, asynchronous call buttons; bit0 = floor 1, bit1 = floor 2, bit2 = floor 3.
- lock_sw  in  1  raw, asynchronous key switch.
- floor_1, floor_2, floor_3  in  1 each  arrival/position indicators from the controller.
- button_1, button_2, button_3  out  1 each  one-cycle request pulses to the controller.
- hold  out  1  one-cycle pulse to the controller on arrival.
- lock  out  1  synchronized lock_sw level.
- pending  out  3  latched call lamps, same bit order as call_in.
- timeout_err  out  1  sticky error flag.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While reset_n = 0, all outputs are 0, synchronizers and counters are 0, and the FSM is in IDLE.
  - last_served resets to floor 3, so floor 1 has first priority.
- Input conditioning:
  - Each call_in bit and lock_sw pass through a 2-FF synchronizer.
  - Each button then has a debounce counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Call latching:
  - A rising edge of a debounced button sets the corresponding pending bit.
  - Re-pressing an already pending floor has no effect.
  - A set and a clear of the same bit in the same cycle: the clear wins, because the car is at that floor.
- lock: equals the synchronized lock_sw, giving 2 cycles of latency from lock_sw. It is not debounced.
- FSM states: IDLE, ISSUE, WAIT_ARRIVE, DWELL.
  - IDLE, when pending != 0 and lock = 0:
    - Select the target round-robin, searching from last_served+1 and wrapping 3 to 1.
    - Go to ISSUE.
    - Otherwise stay in IDLE; pending calls are retained while locked.
  - ISSUE:
    - Assert button_<target> for exactly one cycle; all other button outputs are 0.
    - Clear the timeout counter and go to WAIT_ARRIVE.
  - WAIT_ARRIVE:
    - If floor_<target> = 1: clear pending[target], set last_served = target, go to DWELL.
    - Else if lock = 1: go to IDLE. The call stays pending and no error is raised.
    - Else if the counter reaches TIMEOUT_CYCLES-1: set timeout_err, set last_served = target so that other floors are tried next, and go to IDLE. The call stays pending.
    - Otherwise increment the counter.
  - DWELL:
    - hold = 1 on the first DWELL cycle only.
    - Stay for DWELL_CYCLES cycles total, then go to IDLE.
    - Lock during DWELL does not shorten the dwell.
- Output rules:
  - At most one of button_1/2/3 is high in any cycle.
  - button_N and hold are never high in the same cycle.
- timeout_err is sticky until reset. A new call is still accepted after a timeout.
- Reset mid-operation: any state goes to IDLE immediately, pending is cleared, and no partial pulse is completed.

Decomposition:
- Shared package elevator_pkg holds:
  - The FSM state encoding (2 bits).
  - The floor index constants FLOOR_1..FLOOR_3 (2-bit, values 0..2).
  - NUM_FLOORS = 3.
- One sub-module, elevator_btn_debounce: a 2-FF synchronizer plus debounce counter, parameterized by DEBOUNCE_CYCLES.
  - Instantiated three times, once per call bit.
  - lock_sw uses a bare 2-FF synchronizer.

Test Plan:
- Reset and basic call:
  - Release reset_n, hold call_in=3'b010 for 10 cycles.
  - Expect pending=3'b010 at cycle 2+4 after the press, then a one-cycle button_2 pulse.
  - Drive floor_2=1 five cycles later: expect pending=0 and hold=1 for one cycle, then no button pulses for 8 cycles.
- Round-robin:
  - Press floors 1 and 3 together: floor 1 is served first.
  - After arrival and dwell, button_3 is issued.
  - Press 1 again during the floor-3 wait: the next issue is button_1.
- Lock:
  - lock_sw=1 with pending=3'b100: lock=1 after 2 cycles and no button pulses while locked.
  - After release, button_3 is issued. Lock during WAIT_ARRIVE returns to IDLE with pending kept and timeout_err=0.
- Timeout:
  - Issue button_1 and never drive floor_1: after 64 cycles timeout_err=1 and pending[0] stays 1.
  - With floor 2 also pending, button_2 is issued next.
- Debounce glitch: pulse call_in[2] for 3 cycles → pending stays 0. A 4-cycle stable press → pending[2]=1.
- Reset mid-WAIT: assert reset_n=0 during WAIT_ARRIVE → all outputs 0 immediately, and after release the FSM sits in IDLE with pending=0.
